// File: rtl/bus_initiator_pkg.sv
// bus_initiator_pkg
//   Shared types and constants for the bus initiator:
//   - state_t    : FSM state encoding (IDLE / ACCESS / RESP)
//   - ADDR_W     : bus address width
//   - DATA_W     : bus data width
//   - CNT_W      : wait-cycle counter width
//   - ERROR_DATA : rsp_data value returned for writes and timed-out accesses
package bus_initiator_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  localparam logic [DATA_W-1:0] ERROR_DATA = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/bus_initiator_if.sv
// bus_initiator_if
//   Groups the client command/response handshake and the core-side bus.
//   Signals:
//     cmd_valid/cmd_ready/cmd_we/cmd_address/cmd_write_data : command channel
//     rsp_valid/rsp_ready/rsp_data/rsp_error                : response channel
//     cs/we/address/write_data/read_data/ready              : core bus
//   Modports:
//     master : the initiator's view (drives cmd_ready, rsp_*, cs, we, address, write_data)
//     slave  : the environment's view (client + core), the mirror image
interface bus_initiator_if;
  import bus_initiator_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_address;
  logic [DATA_W-1:0] cmd_write_data;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_error;

  logic              cs;
  logic              we;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              ready;

  modport master (
    input  cmd_valid, cmd_we, cmd_address, cmd_write_data,
    input  rsp_ready, read_data, ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_error,
    output cs, we, address, write_data
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_address, cmd_write_data,
    output rsp_ready, read_data, ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_error,
    input  cs, we, address, write_data
  );

endinterface

// File: rtl/bus_initiator.sv
// bus_initiator
//   Turns one client command at a time into a single bus access toward a
//   core, waits for the core's ready strobe (bounded by TIMEOUT_CYCLES) and
//   returns a response. One command is outstanding at a time.
//   Parameters:
//     TIMEOUT_CYCLES : max cycles cs is held waiting for ready (1..65535)
//   Ports:
//     clk     : clock, rising edge
//     reset_n : asynchronous active-low reset
//     bus     : bus_initiator_if.master (command, response and core bus)
module bus_initiator
  import bus_initiator_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 16'd256
) (
  input  logic            clk,
  input  logic            reset_n,
  bus_initiator_if.master bus
);

  // Counter value of the last permitted wait cycle.
  localparam logic [CNT_W-1:0] LAST_COUNT = TIMEOUT_CYCLES - 16'd1;

  state_t            state_reg;
  logic              cmd_ready_reg;
  logic              cs_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] address_reg;
  logic [DATA_W-1:0] write_data_reg;
  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic              rsp_error_reg;
  logic [CNT_W-1:0]  count_reg;

  // cmd_ready is a register rather than a decode of IDLE so that it is low
  // throughout reset and only rises on the first clock after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      cmd_ready_reg  <= 1'b0;
      cs_reg         <= 1'b0;
      we_reg         <= 1'b0;
      address_reg    <= '0;
      write_data_reg <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_data_reg   <= '0;
      rsp_error_reg  <= 1'b0;
      count_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.cmd_valid && cmd_ready_reg) begin
            state_reg      <= ST_ACCESS;
            cmd_ready_reg  <= 1'b0;
            cs_reg         <= 1'b1;
            we_reg         <= bus.cmd_we;
            address_reg    <= bus.cmd_address;
            write_data_reg <= bus.cmd_write_data;
            count_reg      <= '0;
          end else begin
            cmd_ready_reg  <= 1'b1;
          end
        end

        ST_ACCESS: begin
          // ready wins over the timeout when both land in the same cycle.
          if (bus.ready) begin
            state_reg     <= ST_RESP;
            cs_reg        <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= we_reg ? ERROR_DATA : bus.read_data;
            rsp_error_reg <= 1'b0;
          end else if (count_reg == LAST_COUNT) begin
            state_reg     <= ST_RESP;
            cs_reg        <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= ERROR_DATA;
            rsp_error_reg <= 1'b1;
          end else begin
            count_reg     <= count_reg + 16'd1;
          end
        end

        ST_RESP: begin
          // rsp_data/rsp_error simply hold until the client takes them.
          if (bus.rsp_ready) begin
            state_reg     <= ST_IDLE;
            rsp_valid_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
          end
        end

        default: begin
          state_reg     <= ST_IDLE;
          cmd_ready_reg <= 1'b0;
          cs_reg        <= 1'b0;
          rsp_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_reg;
  assign bus.cs         = cs_reg;
  assign bus.we         = we_reg;
  assign bus.address    = address_reg;
  assign bus.write_data = write_data_reg;
  assign bus.rsp_valid  = rsp_valid_reg;
  assign bus.rsp_data   = rsp_data_reg;
  assign bus.rsp_error  = rsp_error_reg;

endmodule

// File: tb/tb_bus_initiator.sv
// tb_bus_initiator
//   Randomized + directed bench for bus_initiator (TIMEOUT_CYCLES = 8).
//   A behavioural core (memory + programmable wait count) answers the bus;
//   the stimulus process predicts each response from a reference memory and
//   pushes it into a queue; a monitor pops and compares on every response.
module tb_bus_initiator;
  import bus_initiator_pkg::*;

  localparam int TIMEOUT = 8;
  localparam int NEVER   = 1000000;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] data;
    logic        err;
    int          cs_len;
    int          acc_cyc;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   checks;
  int   errors;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [256];
  logic [31:0] core_mem [256];
  int          core_wait;
  int          cur_hold;
  int          cs_cnt;
  int          hs_cyc;
  logic [31:0] garbage;

  bus_initiator_if bus ();

  bus_initiator #(.TIMEOUT_CYCLES(16'd8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    garbage <= $urandom;
  end

  function automatic logic [31:0] init_val(input int i);
    return 32'h5A00_0000 ^ (i * 32'h9E37_79B1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Behavioural core: ready after core_wait stall cycles, read data from core_mem.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cs_cnt <= 0;
    else if (bus.cs) cs_cnt <= cs_cnt + 1;
    else cs_cnt <= 0;
  end
  assign bus.ready     = bus.cs && (cs_cnt == core_wait);
  assign bus.read_data = bus.ready ? core_mem[bus.address] : garbage;

  // Response consumer: hold rsp_ready low for cur_hold cycles of each response.
  int hold;
  always @(posedge clk) begin
    #1;
    if (!bus.rsp_valid) begin
      bus.rsp_ready = 1'b0;
      hold = cur_hold;
    end else if (hold > 0) begin
      hold--;
      bus.rsp_ready = 1'b0;
    end else begin
      bus.rsp_ready = 1'b1;
    end
  end

  // Monitor / scoreboard.
  initial begin
    int   cs_len;
    bit   rsp_seen;
    exp_t cur;
    logic [31:0] held_data;
    logic        held_err;
    for (int i = 0; i < 256; i++) core_mem[i] = init_val(i);
    cs_len = 0;
    rsp_seen = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        cs_len = 0;
        rsp_seen = 0;
      end else begin
        if (bus.cs) begin
          cs_len++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL cs_unexpected actual=1 required=0");
          end else begin
            chk("bus_fields", {bus.we, bus.address, bus.write_data},
                {exp_q[0].we, exp_q[0].addr, exp_q[0].wdata});
            chk("cmd_ready_busy", bus.cmd_ready, 0);
          end
          if (bus.ready && bus.we) core_mem[bus.address] = bus.write_data;
        end
        if (bus.rsp_valid) begin
          if (!rsp_seen) begin
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL rsp_unexpected actual=1 required=0");
            end else begin
              cur = exp_q.pop_front();
              $display("rsp we=%0d addr=%02h data=%08h err=%0d cs_len=%0d",
                       cur.we, cur.addr, bus.rsp_data, bus.rsp_error, cs_len);
              chk("rsp_data", bus.rsp_data, cur.data);
              chk("rsp_error", bus.rsp_error, cur.err);
              chk("cs_len", cs_len, cur.cs_len);
              chk("rsp_latency", cyc, cur.acc_cyc + 1 + cur.cs_len);
              chk("addr_hold", bus.address, cur.addr);
            end
            rsp_seen  = 1;
            held_data = bus.rsp_data;
            held_err  = bus.rsp_error;
            cs_len    = 0;
          end else begin
            chk("rsp_stable", {bus.rsp_data, bus.rsp_error}, {held_data, held_err});
            chk("cmd_ready_stall", bus.cmd_ready, 0);
          end
          if (bus.rsp_ready) hs_cyc = cyc;
        end else begin
          rsp_seen = 0;
        end
      end
    end
  end

  // Issue one command (called at a negedge); returns the accept cycle.
  task automatic issue(input logic we, input logic [7:0] a, input logic [31:0] d,
                       input int wait_c, input int hold_c, output int acc);
    exp_t e;
    int   n;
    bus.cmd_valid      = 1'b1;
    bus.cmd_we         = we;
    bus.cmd_address    = a;
    bus.cmd_write_data = d;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=0 required=1");
      acc = -1;
      bus.cmd_valid = 1'b0;
    end else begin
      e.we = we; e.addr = a; e.wdata = d;
      if (wait_c < TIMEOUT) begin
        e.err = 1'b0;
        e.cs_len = wait_c + 1;
        if (we) begin
          e.data = 32'h0;
          ref_mem[a] = d;
        end else begin
          e.data = ref_mem[a];
        end
      end else begin
        e.err = 1'b1;
        e.data = 32'h0;
        e.cs_len = TIMEOUT;
      end
      e.acc_cyc = cyc;
      acc = cyc;
      core_wait = wait_c;
      cur_hold  = hold_c;
      exp_q.push_back(e);
      @(negedge clk);
      bus.cmd_valid      = 1'b0;
      bus.cmd_we         = 1'($urandom);
      bus.cmd_address    = 8'($urandom);
      bus.cmd_write_data = $urandom;
    end
  endtask

  initial begin
    int a0, a1, a2;
    reset_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_we = 1'b0;
    bus.cmd_address = 8'h00;
    bus.cmd_write_data = 32'h0;
    bus.rsp_ready = 1'b0;
    core_wait = 0;
    cur_hold = 0;
    hs_cyc = 0;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_cs", bus.cs, 0);
    chk("rst_we", bus.we, 0);
    chk("rst_address", bus.address, 0);
    chk("rst_write_data", bus.write_data, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_error", bus.rsp_error, 0);
    reset_n = 1'b1;
    #1 chk("cmd_ready_pre_clk", bus.cmd_ready, 0);
    @(negedge clk);
    chk("cmd_ready_post_rst", bus.cmd_ready, 1);

    // Zero-wait write then read of 0x0b; issue interval must be 3 cycles.
    issue(1'b1, 8'h0b, 32'h0000_1234, 0, 0, a0);
    issue(1'b0, 8'h0b, 32'h0, 0, 0, a1);
    chk("issue_interval", a1 - a0, 3);
    // Write with 3 wait cycles.
    issue(1'b1, 8'h0a, 32'h0000_0064, 3, 0, a0);
    // Core never ready: timeout after 8 cycles.
    issue(1'b0, 8'h20, 32'h0, NEVER, 0, a0);
    // Ready in the last permitted cycle, response stalled 5 cycles.
    issue(1'b0, 8'h0a, 32'h0, TIMEOUT - 1, 5, a0);
    issue(1'b0, 8'h0b, 32'h0, 0, 0, a2);
    chk("accept_after_hs", a2, hs_cyc + 1);

    // Reset in the middle of an access.
    issue(1'b0, 8'h33, 32'h0, NEVER, 0, a0);
    repeat (2) @(negedge clk);
    chk("cs_before_rst", bus.cs, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_cs_async", bus.cs, 0);
    chk("rst_rsp_valid_async", bus.rsp_valid, 0);
    exp_q.delete();
    @(negedge clk);
    chk("rst_cmd_ready_mid", bus.cmd_ready, 0);
    chk("rst_address_mid", bus.address, 0);
    reset_n = 1'b1;
    #1 chk("cmd_ready_pre_clk2", bus.cmd_ready, 0);
    repeat (4) @(negedge clk);
    chk("cmd_ready_post_rst2", bus.cmd_ready, 1);

    // Randomized traffic.
    for (int k = 0; k < 60; k++) begin
      int r;
      int w;
      r = int'($urandom_range(0, 11));
      w = (r == 11) ? NEVER : r;
      issue(1'($urandom), 8'($urandom_range(0, 15)), $urandom, w,
            int'($urandom_range(0, 3)), a0);
    end

    begin
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.rsp_valid) && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("drain", exp_q.size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_initiator.md
BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 16'd256, meaning the maximum number of cycles cs is held waiting for ready (legal range 1..65535).
REQ-002 The module SHALL have port clk  input  1  the single clock; all state is clocked on its rising edge.
REQ-003 The module SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 The module SHALL have port cmd_valid  input  1  command request from the local client.
REQ-005 The module SHALL have port cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-006 The module SHALL have port cmd_we  input  1  1 = write, 0 = read.
REQ-007 The module SHALL have port cmd_address  input  8  target register address.
REQ-008 The module SHALL have port cmd_write_data  input  32  write payload.
REQ-009 The module SHALL have port rsp_valid  output  1  response available.
REQ-010 The module SHALL have port rsp_ready  input  1  client consumes the response.
REQ-011 The module SHALL have port rsp_data  output  32  read data; 0 for writes and errors.
REQ-012 The module SHALL have port rsp_error  output  1  high when the access timed out.
REQ-013 The module SHALL have port cs  output  1  bus select toward a core.
REQ-014 The module SHALL have port we  output  1  bus write enable.
REQ-015 The module SHALL have port address  output  8  bus address.
REQ-016 The module SHALL have port write_data  output  32  bus write data.
REQ-017 The module SHALL have port read_data  input  32  bus read data, valid in the cycle ready is high.
REQ-018 The module SHALL have port ready  input  1  core completion strobe, may be combinational from cs.

Function
REQ-019 The FSM SHALL have states IDLE, ACCESS, RESP; cmd_ready SHALL be high only in IDLE.
REQ-020 IDLE -> ACCESS SHALL occur on cmd_valid & cmd_ready; cmd_we/cmd_address/cmd_write_data SHALL be registered into we/address/write_data at that edge.
REQ-021 cs SHALL be high exactly while in ACCESS; cs, we, address and write_data SHALL be registered outputs, stable for the whole ACCESS period.
REQ-022 In ACCESS with ready=1, the FSM SHALL go to RESP, capture read_data into rsp_data for reads (0 for writes), and clear rsp_error.
REQ-023 A cycle counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with ready=0.
REQ-024 If ready=0 while the counter equals TIMEOUT_CYCLES-1, the FSM SHALL go to RESP with rsp_error=1 and rsp_data=0; cs is therefore high for at most TIMEOUT_CYCLES cycles.
REQ-025 ready=1 in the timeout cycle SHALL take precedence, giving a normal completion.
REQ-026 rsp_valid SHALL be high exactly in RESP; rsp_data and rsp_error SHALL be stable until rsp_valid & rsp_ready, after which the FSM SHALL return to IDLE.
REQ-027 With a zero-wait core, rsp_valid SHALL rise 2 cycles after command acceptance; the minimum issue interval SHALL be 3 cycles.
REQ-028 ready and read_data SHALL be ignored outside ACCESS.
REQ-029 we, address and write_data SHALL hold their last values outside ACCESS.

Reset
REQ-030 Asserting reset_n low SHALL, asynchronously and at any state including mid-access, force the following: IDLE, cs=0, we=0, address=0, write_data=0, rsp_valid=0, rsp_data=0, rsp_error=0, counter=0.
REQ-031 While reset is asserted, cmd_ready SHALL be 0; it SHALL be 1 from the first clock after deassertion.

Structure
REQ-032 Package bus_initiator_pkg SHALL hold the state encoding and the error data constant (32'h0).
REQ-033 The design SHALL be a single module with no sub-modules; the counter width SHALL be 16 bits.

Verification
REQ-034 The bench SHALL cover a read of 8'h0b from a zero-wait core returning 32'h0000_1234: cs is high 1 cycle, and rsp_valid=1 with rsp_data=32'h1234 and rsp_error=0 appears 2 cycles after acceptance.
REQ-035 The bench SHALL cover a write of 8'h0a with 32'h0000_0064 to a core with 3 wait cycles: cs is high 4 cycles, we=1 and write_data is stable throughout, and rsp_data=0.
REQ-036 The bench SHALL cover a core that never asserts ready with TIMEOUT_CYCLES=8: cs is high exactly 8 cycles, then rsp_error=1 and rsp_data=0.
REQ-037 The bench SHALL cover ready arriving in cycle 8 with TIMEOUT_CYCLES=8: the access completes normally with rsp_error=0.
REQ-038 The bench SHALL cover rsp_ready held low for 5 cycles: the response stays stable, cmd_ready stays 0, and a new command is accepted the cycle after the handshake.
REQ-039 The bench SHALL cover reset_n asserted mid-ACCESS: cs drops immediately without waiting for a clock, and no rsp_valid is produced.
